// File: rtl/mc_controller.sv
// mc_controller: TinyMIPS multicycle control FSM; fetches 32-bit instr in 32/WIDTH memready-stretched beats, drives datapath controls, pulses done on retire
module mc_controller #(
  parameter int WIDTH = 8,
  parameter bit WAIT_EN = 1'b1,
  localparam int NBEATS = 32 / WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic              zero,
  input  logic              memready,
  output logic              memread,
  output logic              memwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        aluop,
  output logic [1:0]        pcsource,
  output logic              memtoreg,
  output logic              iord,
  output logic              regdst,
  output logic              regwrite,
  output logic              pcen,
  output logic [NBEATS-1:0] irwrite,
  output logic              done
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTEX, RTWR, ADDIEX, ADDIWR, BEQEX, BNEEX, JEX
  } state_t;
  state_t state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic rdy, last;
  assign rdy = WAIT_EN ? memready : 1'b1;
  assign last = beat_q == 2'(NBEATS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    memread = 1'b0;
    memwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    aluop = 2'b00;
    pcsource = 2'b00;
    memtoreg = 1'b0;
    iord = 1'b0;
    regdst = 1'b0;
    regwrite = 1'b0;
    pcen = 1'b0;
    irwrite = '0;
    done = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = rdy ? NBEATS'(1) << beat_q : '0;
        pcen = rdy;
        beat_d = rdy ? (last ? 2'd0 : beat_q + 2'd1) : beat_q;
        state_d = rdy && last ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        state_d = op == 6'b000000 ? RTEX :
                  op == 6'b100000 || op == 6'b101000 ? MEMADR :
                  op == 6'b001000 ? ADDIEX :
                  op == 6'b000100 ? BEQEX :
                  op == 6'b000101 ? BNEEX :
                  op == 6'b000010 ? JEX : FETCH;
        done = state_d == FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = op == 6'b100000 ? LBRD : SBWR;
      end
      LBRD: begin
        memread = 1'b1;
        iord = 1'b1;
        state_d = rdy ? LBWR : LBRD;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        done = 1'b1;
        state_d = FETCH;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord = 1'b1;
        done = rdy;
        state_d = rdy ? FETCH : SBWR;
      end
      RTEX: begin
        alusrca = 1'b1;
        aluop = 2'b10;
        state_d = RTWR;
      end
      RTWR: begin
        regwrite = 1'b1;
        regdst = 1'b1;
        done = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWR;
      end
      ADDIWR: begin
        regwrite = 1'b1;
        done = 1'b1;
        state_d = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        aluop = 2'b01;
        pcsource = 2'b01;
        pcen = state_q == BEQEX ? zero : ~zero;
        done = 1'b1;
        state_d = FETCH;
      end
      JEX: begin
        pcsource = 2'b10;
        pcen = 1'b1;
        done = 1'b1;
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
        beat_d = '0;
      end
    endcase
    if (rst) begin
      memread = 1'b0;
      memwrite = 1'b0;
      alusrca = 1'b0;
      alusrcb = 2'b00;
      aluop = 2'b00;
      pcsource = 2'b00;
      memtoreg = 1'b0;
      iord = 1'b0;
      regdst = 1'b0;
      regwrite = 1'b0;
      pcen = 1'b0;
      irwrite = '0;
      done = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized and directed checks of mc_controller against a step-list reference model
module tb_mc_controller;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, memready = 1'b1;
  logic [5:0] op = '0;
  wire [18:0] o8, o16, o0;
  int checks = 0, errors = 0, rnd_pct = 100;
  logic [63:0] stall = '0;
  always #5 clk = ~clk;
  assign o16[3:2] = 2'b00;
  mc_controller #(.WIDTH(8), .WAIT_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(o8[18]), .memwrite(o8[17]), .alusrca(o8[16]), .alusrcb(o8[15:14]),
    .aluop(o8[13:12]), .pcsource(o8[11:10]), .memtoreg(o8[9]), .iord(o8[8]),
    .regdst(o8[7]), .regwrite(o8[6]), .pcen(o8[5]), .done(o8[4]), .irwrite(o8[3:0]));
  mc_controller #(.WIDTH(16), .WAIT_EN(1'b1)) u16 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(o16[18]), .memwrite(o16[17]), .alusrca(o16[16]), .alusrcb(o16[15:14]),
    .aluop(o16[13:12]), .pcsource(o16[11:10]), .memtoreg(o16[9]), .iord(o16[8]),
    .regdst(o16[7]), .regwrite(o16[6]), .pcen(o16[5]), .done(o16[4]), .irwrite(o16[1:0]));
  mc_controller #(.WIDTH(8), .WAIT_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(o0[18]), .memwrite(o0[17]), .alusrca(o0[16]), .alusrcb(o0[15:14]),
    .aluop(o0[13:12]), .pcsource(o0[11:10]), .memtoreg(o0[9]), .iord(o0[8]),
    .regdst(o0[7]), .regwrite(o0[6]), .pcen(o0[5]), .done(o0[4]), .irwrite(o0[3:0]));
  typedef struct packed {
    logic mem, rd, wr, iord, asa;
    logic [1:0] asb, aop, psrc;
    logic m2r, rdst, rw;
    logic [1:0] pcm;
    logic dn;
    logic [2:0] beat;
  } step_t;
  step_t q[$];
  function automatic step_t st(logic mem, logic rd, logic wr, logic io, logic asa, logic [1:0] asb,
                               logic [1:0] aop, logic [1:0] psrc, logic m2r, logic rdst, logic rw,
                               logic [1:0] pcm, logic dn, logic [2:0] beat);
    return '{mem, rd, wr, io, asa, asb, aop, psrc, m2r, rdst, rw, pcm, dn, beat};
  endfunction
  function automatic logic [18:0] obs(int w);
    return w == 0 ? o8 : w == 1 ? o16 : o0;
  endfunction
  task automatic build(input logic [5:0] o, input int n);
    logic ill;
    ill = !(o inside {6'h00, 6'h20, 6'h28, 6'h08, 6'h04, 6'h05, 6'h02});
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(st(1, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'd0, 0, 3'(i)));
    q.push_back(st(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'd0, ill, 3'd7));
    if (o == 6'h00) begin
      q.push_back(st(0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 2'd0, 0, 3'd7));
      q.push_back(st(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'd0, 1, 3'd7));
    end
    if (o == 6'h20 || o == 6'h28) q.push_back(st(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'd0, 0, 3'd7));
    if (o == 6'h20) begin
      q.push_back(st(1, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0, 0, 3'd7));
      q.push_back(st(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'd0, 1, 3'd7));
    end
    if (o == 6'h28) q.push_back(st(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0, 1, 3'd7));
    if (o == 6'h08) begin
      q.push_back(st(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'd0, 0, 3'd7));
      q.push_back(st(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'd0, 1, 3'd7));
    end
    if (o == 6'h04 || o == 6'h05)
      q.push_back(st(0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0, 0, o == 6'h04 ? 2'd2 : 2'd3, 1, 3'd7));
    if (o == 6'h02) q.push_back(st(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 2'd1, 1, 3'd7));
  endtask
  // Callers are always just after a falling edge; each loop pass covers one clock cycle.
  task automatic run_instr(input int w, input logic [5:0] o, input logic z, output int cyc);
    step_t s;
    logic r, go, pc;
    logic [3:0] ir;
    logic [18:0] exp;
    op = o;
    zero = z;
    build(o, w == 1 ? 2 : 4);
    cyc = 0;
    while (q.size() > 0 && cyc < 300) begin
      memready = !(cyc < 64 && stall[cyc]) && ($urandom_range(0, 99) < rnd_pct);
      #1;
      s = q[0];
      r = w == 2 ? 1'b1 : memready;
      go = !s.mem || r;
      ir = s.beat != 3'd7 && r ? 4'd1 << s.beat : 4'd0;
      pc = s.beat != 3'd7 ? r : s.pcm == 2'd1 ? 1'b1 : s.pcm == 2'd2 ? z : s.pcm == 2'd3 ? !z : 1'b0;
      exp = {s.rd, s.wr, s.asa, s.asb, s.aop, s.psrc, s.m2r, s.iord, s.rdst, s.rw, pc, s.dn && go, ir};
      checks++;
      if (obs(w) !== exp) begin
        errors++;
        $display("FAIL step w%0d op=%b cyc=%0d got %b exp %b", w, o, cyc, obs(w), exp);
      end
      if (go) void'(q.pop_front());
      cyc++;
      @(negedge clk);
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout w%0d op=%b got %0d steps left exp 0", w, o, q.size());
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    memready = 1'b1;
    #1;
    checks++;
    if ({o8, o16, o0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {o8, o16, o0});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_lat(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latency_%s got %0d exp %0d", nm, got, exp);
    end
  endtask
  task automatic test_reset();
    do_reset();
    memready = 1'b1;
    #1;
    checks++;
    if (o8 !== 19'b1_0_0_01_00_00_0_0_0_0_1_0_0001) begin
      errors++;
      $display("FAIL reset_fetch0 got %b exp %b", o8, 19'b1_0_0_01_00_00_0_0_0_0_1_0_0001);
    end
  endtask
  task automatic test_directed();
    int c;
    do_reset();
    run_instr(0, 6'h00, 1'b0, c);
    chk_lat("rtype", c, 7);
    stall = 64'h0;
    stall[6] = 1'b1;
    stall[7] = 1'b1;
    run_instr(0, 6'h20, 1'b0, c);
    chk_lat("lb_wait", c, 10);
    stall = 64'h0;
    run_instr(0, 6'h08, 1'b0, c);
    chk_lat("addi", c, 7);
    run_instr(0, 6'h04, 1'b1, c);
    chk_lat("beq_taken", c, 6);
    run_instr(0, 6'h05, 1'b1, c);
    chk_lat("bne_nottaken", c, 6);
    run_instr(0, 6'h3f, 1'b0, c);
    chk_lat("illegal", c, 5);
    run_instr(0, 6'h02, 1'b0, c);
    chk_lat("jump", c, 6);
    do_reset();
    stall[1] = 1'b1;
    run_instr(1, 6'h28, 1'b0, c);
    chk_lat("sb16_wait", c, 6);
    stall = 64'h0;
  endtask
  task automatic test_reset_mid();
    op = 6'h00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      memready = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++;
    if (o8 !== 19'b0_0_1_00_10_00_0_0_0_0_0_0_0000) begin
      errors++;
      $display("FAIL mid_rtex got %b exp %b", o8, 19'b0_0_1_00_10_00_0_0_0_0_0_0_0000);
    end
    do_reset();
    test_reset();
  endtask
  task automatic test_nowait();
    int c;
    do_reset();
    rnd_pct = 0;
    run_instr(2, 6'h00, 1'b0, c);
    chk_lat("nowait_rtype", c, 7);
    rnd_pct = 100;
  endtask
  task automatic test_random(input int w, input int pct);
    int c;
    logic [5:0] ops[7] = '{6'h00, 6'h20, 6'h28, 6'h08, 6'h04, 6'h05, 6'h02};
    int idx;
    do_reset();
    rnd_pct = pct;
    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 7);
      run_instr(w, idx < 7 ? ops[idx] : 6'h3f ^ 6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c);
    end
    rnd_pct = 100;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_reset_mid();
    test_nowait();
    test_random(0, 70);
    test_random(1, 60);
    test_random(2, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Parametrised multicycle control FSM for the TinyMIPS datapath. Generalises the fixed 8-bit controller to any memory width dividing 32. Fetches a 32-bit instruction in 32/WIDTH beats and stretches every memory access with a memready handshake. Adds bne and an instruction-retired pulse. Sits between the instruction register opcode field and the datapath mux and enable controls; alucontrol consumes aluop.

Parameters:
WIDTH, 8, memory and datapath width; legal values are 8, 16 and 32. NBEATS = 32/WIDTH is derived and is not overridable.
WAIT_EN, 1, 1 = honour memready; 0 = memready is ignored and treated as 1 (single-cycle memory).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
op  in  6  instr[31:26] from the instruction register
zero  in  1  ALU zero flag
memready  in  1  memory access completes in this cycle
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = constant 1, 10 = immediate, 11 = shifted immediate
aluop  out  2  00 = add, 01 = sub, 10 = use funct
pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
memtoreg  out  1  register write data comes from memory
iord  out  1  0 = address from PC, 1 = address from ALUOut
regdst  out  1  1 = rd, 0 = rt
regwrite  out  1  register file write enable
pcen  out  1  PC write enable
irwrite  out  NBEATS  one-hot instruction-register lane write; bit i loads bits [WIDTH*(i+1)-1 : WIDTH*i]
done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset:
  - rst sampled on the clk rising edge sets state to FETCH with beat = 0.
  - While rst is high, all outputs are forced to 0, overriding the state decode.
  - Reset mid-instruction abandons that instruction: no pcen, regwrite or memwrite occurs in the cycle rst is high.
- Outputs are a Moore decode of state. The only gating is by rdy (memready, or 1 if WAIT_EN = 0) and by zero as noted below. Any output not listed for a state is 0.
- FETCH (beat counter b, 0..NBEATS-1):
  - Outputs: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsource = 00.
  - irwrite[b] = rdy and pcen = rdy.
  - If rdy, b increments; at b = NBEATS-1 with rdy, go to DECODE and reset b to 0.
  - If not rdy, hold state and b with no writes.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, aluop = 00 (precomputes the branch target).
  - Next state by op: 000000 → RTEX, 100000 (lb) → MEMADR, 101000 (sb) → MEMADR, 001000 (addi) → ADDIEX, 000100 (beq) → BEQEX, 000101 (bne) → BNEEX, 000010 (j) → JEX.
  - Any other op → FETCH with done = 1. The instruction is a no-op.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next is LBRD for lb, SBWR for sb.
- LBRD: memread = 1, iord = 1. Holds until rdy, then goes to LBWR.
- LBWR: regwrite = 1, memtoreg = 1, regdst = 0, done = 1. Next is FETCH.
- SBWR: memwrite = 1, iord = 1. Holds until rdy; done = rdy. Then FETCH.
- RTEX: alusrca = 1, alusrcb = 00, aluop = 10. Next is RTWR.
- RTWR: regwrite = 1, regdst = 1, memtoreg = 0, done = 1. Next is FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Next is ADDIWR.
- ADDIWR: regwrite = 1, regdst = 0, done = 1. Next is FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, pcsource = 01, pcen = zero, done = 1. Next is FETCH.
- BNEEX: same as BEQEX except pcen = ~zero.
- JEX: pcsource = 10, pcen = 1, done = 1. Next is FETCH.
- op is sampled only in DECODE and MEMADR. The instruction register is stable there because irwrite = 0.
- Latency with rdy held at 1, counted in cycles from the first FETCH beat to done inclusive, N = NBEATS:
  - R-type, addi, sb: N+3
  - lb: N+4
  - beq, bne, j: N+2
  - illegal op: N+1
- memwrite and memread are never asserted together. irwrite has at most one bit set.
- An unreachable state encoding recovers to FETCH with beat 0.

Test Plan:
- WIDTH = 8, rdy = 1, op = 000000: four FETCH beats with irwrite = 0001, 0010, 0100, 1000 and pcen = 1 each, then DECODE, RTEX (aluop = 10), RTWR (regwrite = 1, regdst = 1, done = 1). Total 7 cycles.
- WIDTH = 8, op = 100000, memready low for 2 cycles in LBRD: memread = iord = 1 holds 3 cycles, then LBWR with regwrite = memtoreg = 1. done at cycle 10.
- WIDTH = 16, op = 101000, memready low on fetch beat 1 for 1 cycle: irwrite = 10 and pcen asserted only in the ready cycle. In SBWR, memwrite = 1 and done = 1 when memready = 1.
- beq with zero = 1 → pcen = 1, pcsource = 01. bne with zero = 1 → pcen = 0. Both pulse done after N+2 cycles.
- op = 111111: DECODE → FETCH, done = 1, no regwrite/memwrite/pcen in the DECODE cycle. j gives pcsource = 10, pcen = 1.
- rst asserted during RTEX: all outputs 0 that cycle, next cycle FETCH beat 0 with irwrite[0] = rdy. WAIT_EN = 0 with memready = 0 completes fetch in N cycles.
